adc_sample_fifo: RTL and testbench
==================================

Name: adc_sample_fifo

Overview:
Capture stage directly downstream of the ADC conversion-strobe logic.
- Watches the `cnv` strobe from the control subsystem and detects its falling edge.
- Waits a fixed number of `clk_in` cycles for the ADC parallel bus to settle, then latches the 16-bit ADC word.
- Buffers captured words in a small synchronous FIFO so the dither/optimiser datapath can pull samples with a read handshake, decoupled from conversion timing.

Parameters:
- DATA_W, 16: ADC sample width.
- DEPTH, 16: FIFO depth in words; power of two, at least 2.
- CAPTURE_DELAY, 5: cycles from the cnv falling-edge detect cycle to the capture cycle; at least 1.
- AVG_LOG2, 2: log2 of averaging window; used only with ADC_SAMPLE_AVG_EN.

Ports:
- clk_in  input  1: system clock; all logic on its rising edge.
- reset  input  1: synchronous, active-high reset.
- enable  input  1: capture enable; reads remain allowed when low.
- cnv  input  1: ADC conversion strobe from the subsystem.
- data  input  DATA_W: ADC parallel output word, unsigned.
- rd_en  input  1: read request from the consumer.
- clear_overflow  input  1: clears the sticky overflow flag.
- rd_data  output  DATA_W: registered FIFO output word.
- rd_valid  output  1: rd_data holds a newly popped word this cycle.
- empty  output  1: FIFO holds no words.
- full  output  1: FIFO holds DEPTH words.
- count  output  $clog2(DEPTH+1): current occupancy.
- capture_pulse  output  1: one-cycle strobe in the capture cycle; for monitoring.
- overflow  output  1: sticky; a push was dropped because the FIFO was full.

Behaviour:
- Clocking and reset:
  - One clock (clk_in); reset is synchronous and active-high.
  - Reset clears all outputs to 0 except empty, which resets to 1.
  - Reset also clears cnv_d, pointers, delay counter and accumulator; state goes to IDLE.
  - Reset mid-delay aborts the pending capture; no write occurs.
- Edge detect:
  - cnv_d is cnv registered.
  - edge = cnv_d & ~cnv, combinational. Call the cycle in which edge is high cycle E.
- State machine (IDLE, DELAY, CAPTURE):
  - IDLE: if enable & edge, load dly_cnt = CAPTURE_DELAY-1 and go to DELAY. When CAPTURE_DELAY=1, go straight to CAPTURE.
  - DELAY: decrement dly_cnt each cycle; when dly_cnt==1 go to CAPTURE.
  - CAPTURE: active in cycle E+CAPTURE_DELAY.
    - capture_pulse=1.
    - data sampled at the end of this cycle is pushed.
    - Return to IDLE.
  - Edges arriving in DELAY or CAPTURE are ignored. The cnv period must exceed CAPTURE_DELAY+1.
  - enable falling in DELAY or CAPTURE: abort, no push, IDLE next cycle. FIFO contents are retained.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - count tracks occupancy; full = (count==DEPTH); empty = (count==0).
  - Push when not full: write at wr_ptr, increment wr_ptr.
  - Push when full with no pop in the same cycle: word dropped, overflow<=1, pointers unchanged.
  - Pop (rd_en & ~empty): rd_data<=mem[rd_ptr], rd_valid=1 next cycle, rd_ptr increments. Read latency is 1 cycle.
  - rd_en while empty: ignored; rd_valid=0 next cycle; rd_data holds its last value.
  - Simultaneous push and pop:
    - Both are performed and count is unchanged.
    - When full, the pop frees a slot, so the push is accepted and overflow does not set.
    - When empty, the push is accepted and the pop is ignored: no write-through, and rd_valid=0 next cycle.
- overflow: set by a dropped push; cleared by clear_overflow. If both occur in the same cycle, set wins.

Optional Feature:
Macro ADC_SAMPLE_AVG_EN.
- Defined:
  - Each capture adds data into an accumulator of width DATA_W+AVG_LOG2.
  - After 2^AVG_LOG2 captures, push acc>>AVG_LOG2 (truncate, unsigned) and clear acc in the same cycle.
  - capture_pulse still fires on every capture.
  - Reset and enable-low clear acc and the capture counter.
- Undefined: every capture pushes data directly; no accumulator or averaging logic is synthesised.

Decomposition:
- Package adc_capture_pkg:
  - typedef adc_sample_t = logic [15:0].
  - enum cap_state_t {IDLE, DELAY, CAPTURE}.
  - localparam default CAPTURE_DELAY=5.
- Sub-module sync_fifo (parameters DATA_W, DEPTH) holds the FIFO storage, pointers, count and flags.
- adc_sample_fifo holds edge detect, state machine, optional averager and overflow logic.

Test Plan:
- Drive cnv 1→0 at cycle 10 with data=16'h1234 held. Expect capture_pulse in cycle 15 only, then rd_en gives rd_data=16'h1234 with rd_valid one cycle later.
- Drive 16 conversions with data=0..15 and no reads. Expect full=1 and count=16. A 17th conversion gives overflow=1 and count stays 16. Sixteen pops return 0..15 in order; then empty=1.
- With FIFO full, assert rd_en in the capture cycle of a new conversion with data=16'hAAAA. Expect count stays 16, overflow stays 0, and the last pop returns 16'hAAAA.
- Assert reset in cycle E+2 of a pending capture. Expect no capture_pulse, count=0, empty=1, and all outputs at reset values.
- Drop enable in cycle E+3. Expect no push. A later edge with enable=1 captures normally. Also issue a second cnv falling edge at E+2 during DELAY; expect it is ignored.
- With ADC_SAMPLE_AVG_EN and AVG_LOG2=2, capture data 10, 20, 30, 41. Expect a single push of 25 after the 4th capture, and capture_pulse asserted 4 times.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture path.
package adc_capture_pkg;

  typedef logic [15:0] adc_sample_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    CAPTURE
  } cap_state_t;

  localparam int unsigned DEFAULT_CAPTURE_DELAY = 5;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with registered read port, occupancy count and flags.
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_c;
  logic              wr_c;
  logic [CNT_W-1:0]  count_next_c;

  // A pop on an empty FIFO is ignored, so a same-cycle push never writes through.
  // A pop on a full FIFO frees the slot the push lands in.
  assign pop_c        = rd_en & ~empty;
  assign wr_c         = push & (~full | pop_c);
  assign count_next_c = count + CNT_W'(wr_c) - CNT_W'(pop_c);

  always_ff @(posedge clk_in) begin
    if (wr_c) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= pop_c;
      count    <= count_next_c;
      empty    <= (count_next_c == CNT_W'(0));
      full     <= (count_next_c == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC capture stage: cnv falling-edge detect, settle delay, capture into a sample FIFO.
// Define ADC_SAMPLE_AVG_EN to push the mean of every 2**AVG_LOG2 captures instead.
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned CAPTURE_DELAY = DEFAULT_CAPTURE_DELAY
`ifdef ADC_SAMPLE_AVG_EN
  ,
  parameter int unsigned AVG_LOG2      = 2
`endif
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       cnv,
  input  logic [DATA_W-1:0]          data,
  input  logic                       rd_en,
  input  logic                       clear_overflow,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       capture_pulse,
  output logic                       overflow
);

  localparam int unsigned DLY_W = $clog2(CAPTURE_DELAY + 1);

  cap_state_t        state;
  cap_state_t        state_next;
  logic [DLY_W-1:0]  dly_cnt;
  logic [DLY_W-1:0]  dly_next;
  logic              cnv_d;
  logic              cnv_fall_c;
  logic              capture_c;
  logic              push_c;
  logic [DATA_W-1:0] push_data_c;

  assign cnv_fall_c = cnv_d & ~cnv;

  // State register; capture_pulse is registered so it is high exactly while in CAPTURE.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state         <= IDLE;
      dly_cnt       <= '0;
      cnv_d         <= 1'b0;
      capture_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      dly_cnt       <= dly_next;
      cnv_d         <= cnv;
      capture_pulse <= (state_next == CAPTURE);
    end
  end

  // Edges seen outside IDLE are ignored; dropping enable aborts a pending capture.
  always_comb begin
    state_next = state;
    dly_next   = dly_cnt;
    capture_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && cnv_fall_c) begin
          if (CAPTURE_DELAY == 1) begin
            state_next = CAPTURE;
          end else begin
            state_next = DELAY;
            dly_next   = DLY_W'(CAPTURE_DELAY - 1);
          end
        end
      end
      DELAY: begin
        if (!enable) begin
          state_next = IDLE;
        end else begin
          dly_next = dly_cnt - DLY_W'(1);
          if (dly_cnt == DLY_W'(1)) state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
        capture_c  = enable;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ADC_SAMPLE_AVG_EN
  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum_c;
  logic [AVG_LOG2-1:0] avg_cnt;

  assign acc_sum_c = acc + ACC_W'(data);

  // Accumulate a window of captures; the last one pushes the mean and restarts.
  always_ff @(posedge clk_in) begin
    if (reset || !enable) begin
      acc     <= '0;
      avg_cnt <= '0;
    end else if (capture_c) begin
      avg_cnt <= avg_cnt + AVG_LOG2'(1);
      acc     <= (avg_cnt == '1) ? '0 : acc_sum_c;
    end
  end

  assign push_c      = capture_c && (avg_cnt == '1);
  assign push_data_c = DATA_W'(acc_sum_c >> AVG_LOG2);
`else
  assign push_c      = capture_c;
  assign push_data_c = data;
`endif

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_c && full && !rd_en) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data_c),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Bench for adc_sample_fifo: conversion vector table, hand-written corner sequences,
// and a read-side scoreboard queue of expected samples.
module tb_adc_sample_fifo;
  import adc_capture_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        enable;
  logic        cnv;
  adc_sample_t data;
  logic        rd_en;
  logic        clear_overflow;
  adc_sample_t rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        capture_pulse;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;

  adc_sample_t exp_q[$];

  typedef struct {
    adc_sample_t data;
    int          exp_count;
    bit          exp_full;
    bit          exp_ovf;
    bit          queued;
  } vec_t;

  vec_t vecs[17];

  adc_sample_fifo #(
    .DATA_W        (16),
    .DEPTH         (16),
    .CAPTURE_DELAY (5)
  ) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .enable         (enable),
    .cnv            (cnv),
    .data           (data),
    .rd_en          (rd_en),
    .clear_overflow (clear_overflow),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .capture_pulse  (capture_pulse),
    .overflow       (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " rd_data"},       32'(rd_data),       32'd0);
    check({tag, " rd_valid"},      32'(rd_valid),      32'd0);
    check({tag, " empty"},         32'(empty),         32'd1);
    check({tag, " full"},          32'(full),          32'd0);
    check({tag, " count"},         32'(count),         32'd0);
    check({tag, " capture_pulse"}, 32'(capture_pulse), 32'd0);
    check({tag, " overflow"},      32'(overflow),      32'd0);
  endtask

  // One conversion: falling edge in cycle E, pulse expected only at E+5.
  task automatic convert(input adc_sample_t val, input bit queued, input bit rd_at_cap);
    adc_sample_t exp_rd;
    cnv = 1'b1;
    step();
    cnv  = 1'b0;
    data = val;
    for (int k = 0; k <= 6; k++) begin
      check($sformatf("capture_pulse E+%0d", k), 32'(capture_pulse), 32'(k == 5));
      if (k == 6 && rd_at_cap) begin
        exp_rd = exp_q.pop_front();
        check("rd_valid at capture", 32'(rd_valid), 32'd1);
        check("rd_data at capture",  32'(rd_data),  32'(exp_rd));
      end
      rd_en = (k == 5) && rd_at_cap;
      step();
    end
    rd_en = 1'b0;
    if (queued) exp_q.push_back(val);
  endtask

  task automatic pop_check(input string tag);
    adc_sample_t exp_rd;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, " rd_valid (empty)"}, 32'(rd_valid), 32'd0);
    end else begin
      exp_rd = exp_q.pop_front();
      check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
      check({tag, " rd_data"},  32'(rd_data),  32'(exp_rd));
    end
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    cnv            = 1'b1;
    rd_en          = 1'b0;
    clear_overflow = 1'b0;
    data           = '0;
    repeat (3) step();
    reset = 1'b0;
    check_reset_state("por");

`ifdef ADC_SAMPLE_AVG_EN
    convert(16'd10, 1'b0, 1'b0);
    convert(16'd20, 1'b0, 1'b0);
    convert(16'd30, 1'b0, 1'b0);
    check("avg count before window end", 32'(count), 32'd0);
    convert(16'd41, 1'b0, 1'b0);
    check("avg count after window", 32'(count), 32'd1);
    exp_q.push_back(16'd25);
    pop_check("avg mean");
    check("avg empty", 32'(empty), 32'd1);
`else
    // Single capture and 1-cycle read latency.
    convert(16'h1234, 1'b1, 1'b0);
    check("single count", 32'(count), 32'd1);
    check("single empty", 32'(empty), 32'd0);
    pop_check("single");
    step();
    check("rd_valid one cycle", 32'(rd_valid), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("empty read rd_valid", 32'(rd_valid), 32'd0);
    check("empty read rd_data hold", 32'(rd_data), 32'h1234);

    // Fill to full, then one dropped push.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{data: adc_sample_t'(i), exp_count: i + 1, exp_full: (i == 15),
                  exp_ovf: 1'b0, queued: 1'b1};
    vecs[16] = '{data: 16'hDEAD, exp_count: 16, exp_full: 1'b1, exp_ovf: 1'b1, queued: 1'b0};
    for (int i = 0; i < 17; i++) begin
      convert(vecs[i].data, vecs[i].queued, 1'b0);
      check($sformatf("vec%0d count", i),    32'(count),    32'(vecs[i].exp_count));
      check($sformatf("vec%0d full", i),     32'(full),     32'(vecs[i].exp_full));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("overflow cleared", 32'(overflow), 32'd0);
    check("count after clear", 32'(count), 32'd16);

    // Push and pop together while full.
    convert(16'hAAAA, 1'b1, 1'b1);
    check("full push+pop count",    32'(count),    32'd16);
    check("full push+pop full",     32'(full),     32'd1);
    check("full push+pop overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i));
    check("drained empty", 32'(empty), 32'd1);
    check("drained count", 32'(count), 32'd0);

    // Reset during the settle delay.
    convert(16'h5555, 1'b1, 1'b0);
    pop_check("pre-reset");
    convert(16'h6666, 1'b1, 1'b0);
    check("pre-reset count", 32'(count), 32'd1);
    cnv = 1'b1;
    step();
    cnv  = 1'b0;
    data = 16'h7777;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check_reset_state("mid-delay reset");
    for (int k = 3; k <= 8; k++) begin
      check($sformatf("post-reset pulse E+%0d", k), 32'(capture_pulse), 32'd0);
      step();
    end
    check("post-reset count", 32'(count), 32'd0);

    // Enable dropped at E+3, with a stray edge at E+2.
    cnv = 1'b1;
    step();
    cnv  = 1'b0;
    data = 16'hBEEF;
    for (int k = 0; k <= 8; k++) begin
      check($sformatf("en-drop pulse E+%0d", k), 32'(capture_pulse), 32'd0);
      case (k)
        1: cnv = 1'b1;
        2: cnv = 1'b0;
        3: enable = 1'b0;
        4: enable = 1'b1;
        default: ;
      endcase
      step();
    end
    check("en-drop count", 32'(count), 32'd0);

    // A second edge during DELAY must not restart the delay.
    cnv = 1'b1;
    step();
    cnv  = 1'b0;
    data = 16'hC0DE;
    for (int k = 0; k <= 8; k++) begin
      check($sformatf("dbl-edge pulse E+%0d", k), 32'(capture_pulse), 32'(k == 5));
      if (k == 1) cnv = 1'b1;
      if (k == 2) cnv = 1'b0;
      step();
    end
    exp_q.push_back(16'hC0DE);
    check("dbl-edge count", 32'(count), 32'd1);
    convert(16'h0F0F, 1'b1, 1'b0);
    check("recovered count", 32'(count), 32'd2);
    pop_check("dbl-edge pop0");
    pop_check("dbl-edge pop1");
    check("final empty", 32'(empty), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
